// File: rtl/shift_deserializer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_deserializer_if : serial strobe/data in, parallel word out with
//                         valid/ready handshake and status flags
// Revision 1.0
// ---------------------------------------------------------------------------
interface shift_deserializer_if #(
  parameter int N = 4
);
  localparam int CW = $clog2(N + 1);

  logic          en;
  logic          si;
  logic          clr;
  logic          ready;
  logic [N-1:0]  dout;
  logic          valid;
  logic          overrun;
  logic [CW-1:0] count;
  logic          perr;

  modport master (
    output en, si, clr, ready,
    input  dout, valid, overrun, count, perr
  );

  modport slave (
    input  en, si, clr, ready,
    output dout, valid, overrun, count, perr
  );
endinterface
`default_nettype wire

// File: rtl/shift_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// shift_deserializer : LSB-first serial-in, parallel-out receiver with
//                      held output word, valid/ready and sticky overrun.
//                      Optional parity bit: SHIFT_DESERIALIZER_PARITY_EN
// Revision 1.0
// ---------------------------------------------------------------------------
module shift_deserializer #(
  parameter int N = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  shift_deserializer_if.slave bus
);
  localparam int CW = $clog2(N + 1);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  localparam logic [CW-1:0] C_LAST = CW'(N);
`else
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
`endif

  logic [N-1:0]  r_shreg;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_dout;
  logic          r_valid;
  logic          r_overrun;
  logic          r_perr;

  logic          w_last;
  logic          w_complete;
  logic          w_accept;
  logic [N-1:0]  w_word;
  logic          w_perr;

  always_comb begin
    w_last     = (r_count == C_LAST);
    w_complete = bus.en && !bus.clr && w_last;
    // a completed word may load when the slot is empty or drains this edge
    w_accept   = !r_valid || bus.ready;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    // the final strobe carries the parity bit, data is already in shreg
    w_word     = r_shreg;
    w_perr     = (^r_shreg) ^ bus.si;
`else
    w_word     = {bus.si, r_shreg[N-1:1]};
    w_perr     = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg   <= '0;
      r_count   <= '0;
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end

      if (bus.clr) begin
        r_shreg   <= '0;
        r_count   <= '0;
        r_overrun <= 1'b0;
      end else if (bus.en) begin
        if (w_last) begin
          r_count <= '0;
`ifndef SHIFT_DESERIALIZER_PARITY_EN
          r_shreg <= {bus.si, r_shreg[N-1:1]};
`endif
          if (w_accept) begin
            r_dout  <= w_word;
            r_perr  <= w_perr;
            r_valid <= 1'b1;
          end else begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_shreg <= {bus.si, r_shreg[N-1:1]};
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign bus.dout    = r_dout;
  assign bus.valid   = r_valid;
  assign bus.overrun = r_overrun;
  assign bus.count   = r_count;
  assign bus.perr    = r_perr;

endmodule
`default_nettype wire
